// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the multicycle memory sequencer.
// Holds the FSM state encoding, latency bound and default widths.
package mem_seq_pkg;

    localparam int MAX_LAT    = 4;
    localparam int CNT_W      = $clog2(MAX_LAT);
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_RAM_AW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } memState_t;

    // Counter preload for a given latency: WAIT lasts lat cycles ending at zero.
    function automatic logic [CNT_W-1:0] latLoad(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// CPU-side request/response bundle between the control FSM and the sequencer.
interface mem_access_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              Req;
    logic              WE;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] RData;
    logic              Fault;

    modport master (output Req, WE, Addr, WData, input  Busy, Done, RData, Fault);
    modport slave  (input  Req, WE, Addr, WData, output Busy, Done, RData, Fault);
endinterface

// File: rtl/mem_access_seq_lat_counter.sv
// Purpose: loadable down-counter with zero flag, times the RAM wait window.
// Latency: load/decrement visible the cycle after the enabling edge.
// Backpressure: none; saturates at zero instead of wrapping.
module mem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] loadVal,
    output logic [W-1:0] count,
    output logic         zero
);
    always_ff @(posedge clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/mem_access_seq.sv
// Purpose: issues one RAM access per request, waits fixed latency, latches read data.
// Latency: Req in cycle k -> Done in cycle k+LAT+2 (LAT = RD_LAT or WR_LAT).
// Backpressure: Busy high in ISSUE/WAIT; Req outside IDLE is dropped. Macro: MEM_ALIGN_CHECK_EN.
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RAM_AW = DEF_RAM_AW,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              Reset,
    mem_access_seq_if.slave   cpu,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    if ((RD_LAT < 1) || (RD_LAT > MAX_LAT) || (WR_LAT < 1) || (WR_LAT > MAX_LAT)) begin : gBadLat
        $error("mem_access_seq: RD_LAT/WR_LAT must be in 1..%0d", MAX_LAT);
    end
    if (RAM_AW + 2 > ADDR_W) begin : gBadAw
        $error("mem_access_seq: RAM_AW+2 exceeds ADDR_W");
    end

    localparam logic [CNT_W-1:0] RD_LOAD = latLoad(RD_LAT);
    localparam logic [CNT_W-1:0] WR_LOAD = latLoad(WR_LAT);

    memState_t         state, nextState;
    logic              capWe;
    logic [RAM_AW-1:0] capRamAddr;
    logic [DATA_W-1:0] capWData;
    logic [DATA_W-1:0] rdataQ;
    logic [CNT_W-1:0]  cnt;
    logic              cntZero;
    logic              reqAccept;

    assign reqAccept = (state == IDLE) && cpu.Req;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (cpu.Req) begin
`ifdef MEM_ALIGN_CHECK_EN
                    nextState = (cpu.Addr[1:0] != 2'b00) ? FAULT : ISSUE;
`else
                    nextState = ISSUE;
`endif
                end
            end
            ISSUE:   nextState = WAIT;
            WAIT:    nextState = cntZero ? DONE : WAIT;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        cpu.Busy  = 1'b0;
        cpu.Done  = 1'b0;
        cpu.Fault = 1'b0;
        ram_en    = 1'b0;
        case (state)
            ISSUE:   begin cpu.Busy = 1'b1; ram_en = 1'b1; end
            WAIT:    cpu.Busy = 1'b1;
            DONE:    cpu.Done = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            FAULT:   cpu.Fault = 1'b1;
`endif
            default: ;
        endcase
    end

    // Request fields are frozen at acceptance so later bus changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (Reset) begin
            capWe      <= 1'b0;
            capRamAddr <= '0;
            capWData   <= '0;
        end else if (reqAccept) begin
            capWe      <= cpu.WE;
            capRamAddr <= cpu.Addr[RAM_AW+1:2];
            capWData   <= cpu.WData;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rdataQ <= '0;
        end else if ((state == WAIT) && cntZero && !capWe) begin
            rdataQ <= ram_rdata;
        end
    end

    mem_lat_counter #(.W(CNT_W)) uLatCnt (
        .clk     (clk),
        .Reset   (Reset),
        .load    (state == ISSUE),
        .dec     (state == WAIT),
        .loadVal (capWe ? WR_LOAD : RD_LOAD),
        .count   (cnt),
        .zero    (cntZero)
    );

    assign cpu.RData = rdataQ;
    assign ram_wr    = ram_en & capWe;
    assign ram_addr  = capRamAddr;
    assign ram_wdata = capWData;
endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: dut0 RD_LAT=1/WR_LAT=1, dut1 RD_LAT=3/WR_LAT=2, scoreboarded.
module tb_mem_access_seq;
    typedef struct { int id; int at; logic [7:0] addr; logic wr; logic [31:0] wd; } ramExp_t;
    typedef struct { int id; int at; logic [31:0] r; } doneExp_t;
    typedef struct { int id; int at; } faultExp_t;
    typedef struct { int id; int at; logic busy; logic chkR; logic [31:0] r; } probe_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;
    int   nTests = 0;
    int   nFail = 0;

    logic        req[2], we[2];
    logic [31:0] addr[2], wdata[2];
    logic        doneS[2], busyS[2], faultS[2], ramEn[2], ramWr[2];
    logic [7:0]  ramAddr[2];
    logic [31:0] ramWdata[2], ramRdata[2], rdataS[2];
    logic [31:0] mem[2][256];
    logic [31:0] pipe[2][4];

    ramExp_t   ramQ[$];
    doneExp_t  doneQ[$];
    faultExp_t faultQ[$];
    probe_t    probeQ[$];
    ramExp_t   re;
    doneExp_t  de;
    faultExp_t fe;
    probe_t    pe;

    mem_access_seq_if #(.DATA_W(32), .ADDR_W(32)) ifA();
    mem_access_seq_if #(.DATA_W(32), .ADDR_W(32)) ifB();

    assign ifA.Req = req[0];  assign ifA.WE = we[0];  assign ifA.Addr = addr[0];  assign ifA.WData = wdata[0];
    assign ifB.Req = req[1];  assign ifB.WE = we[1];  assign ifB.Addr = addr[1];  assign ifB.WData = wdata[1];
    assign doneS[0] = ifA.Done;  assign busyS[0] = ifA.Busy;  assign faultS[0] = ifA.Fault;  assign rdataS[0] = ifA.RData;
    assign doneS[1] = ifB.Done;  assign busyS[1] = ifB.Busy;  assign faultS[1] = ifB.Fault;  assign rdataS[1] = ifB.RData;

    mem_access_seq #(.DATA_W(32), .ADDR_W(32), .RAM_AW(8), .RD_LAT(1), .WR_LAT(1)) dut0 (
        .clk(clk), .Reset(Reset), .cpu(ifA),
        .ram_en(ramEn[0]), .ram_wr(ramWr[0]), .ram_addr(ramAddr[0]),
        .ram_wdata(ramWdata[0]), .ram_rdata(ramRdata[0])
    );
    mem_access_seq #(.DATA_W(32), .ADDR_W(32), .RAM_AW(8), .RD_LAT(3), .WR_LAT(2)) dut1 (
        .clk(clk), .Reset(Reset), .cpu(ifB),
        .ram_en(ramEn[1]), .ram_wr(ramWr[1]), .ram_addr(ramAddr[1]),
        .ram_wdata(ramWdata[1]), .ram_rdata(ramRdata[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data emerges after a delay line; idle slots carry a poison word.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                mem[0][4] <= 32'hDEADBEEF;  mem[0][5] <= 32'h0BADCAFE;
                mem[1][0] <= 32'h11223344;  mem[1][1] <= 32'hCAFEF00D;
            end else if (ramEn[i] && ramWr[i]) begin
                mem[i][ramAddr[i]] <= ramWdata[i];
            end
            pipe[i][0] <= (ramEn[i] && !ramWr[i]) ? mem[i][ramAddr[i]] : 32'hBAD0BAD0;
            for (int j = 1; j < 4; j++) pipe[i][j] <= pipe[i][j-1];
        end
    end
    assign ramRdata[0] = pipe[0][0];
    assign ramRdata[1] = pipe[1][2];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (doneS[i] === 1'b1) begin
                if (doneQ.size() == 0) chk($sformatf("unexpected_done_dut%0d", i), 32'd1, 32'd0);
                else begin
                    de = doneQ.pop_front();
                    chk("done_dut", 32'(i), 32'(de.id));
                    chk("done_cycle", 32'(cyc), 32'(de.at));
                    chk("done_rdata", rdataS[i], de.r);
                end
            end
            if (ramEn[i] === 1'b1) begin
                if (ramQ.size() == 0) chk($sformatf("unexpected_ram_en_dut%0d", i), 32'd1, 32'd0);
                else begin
                    re = ramQ.pop_front();
                    chk("ram_dut", 32'(i), 32'(re.id));
                    chk("ram_cycle", 32'(cyc), 32'(re.at));
                    chk("ram_addr", 32'(ramAddr[i]), 32'(re.addr));
                    chk("ram_wr", 32'(ramWr[i]), 32'(re.wr));
                    if (re.wr) chk("ram_wdata", ramWdata[i], re.wd);
                end
            end
            if (faultS[i] === 1'b1) begin
                if (faultQ.size() == 0) chk($sformatf("unexpected_fault_dut%0d", i), 32'd1, 32'd0);
                else begin
                    fe = faultQ.pop_front();
                    chk("fault_dut", 32'(i), 32'(fe.id));
                    chk("fault_cycle", 32'(cyc), 32'(fe.at));
                end
            end
        end
        while (probeQ.size() > 0 && probeQ[0].at <= cyc) begin
            pe = probeQ.pop_front();
            chk("probe_cycle", 32'(cyc), 32'(pe.at));
            chk($sformatf("busy_dut%0d", pe.id), 32'(busyS[pe.id]), 32'(pe.busy));
            if (pe.chkR) chk($sformatf("rdata_dut%0d", pe.id), rdataS[pe.id], pe.r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request pulse; expected RAM slot and Done are hand-supplied by the caller.
    task automatic acc(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] ea, input int off, input logic [31:0] er);
        ramQ.push_back(ramExp_t'{id: id, at: cyc + 1, addr: ea, wr: w, wd: d});
        doneQ.push_back(doneExp_t'{id: id, at: cyc + off, r: er});
        req[id] = 1'b1;  we[id] = w;  addr[id] = a;  wdata[id] = d;
        tick();
        req[id] = 1'b0;
        repeat (off) tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;  we[i] = 1'b0;  addr[i] = '0;  wdata[i] = '0;
        end
        tick();
        for (int i = 0; i < 2; i++) probeQ.push_back(probe_t'{id: i, at: cyc, busy: 1'b0, chkR: 1'b1, r: 32'h0});
        tick();
        Reset = 1'b0;
        tick();

        // dut0 (RD_LAT=1, WR_LAT=1)
        acc(0, 1'b0, 32'h10, 32'h0, 8'd4, 3, 32'hDEADBEEF);
        acc(0, 1'b1, 32'h20, 32'h12345678, 8'd8, 3, 32'hDEADBEEF);

        // Req held high: second access starts at the next IDLE cycle with the new address.
        n = cyc;
        ramQ.push_back(ramExp_t'{id: 0, at: n + 1, addr: 8'd4, wr: 1'b0, wd: 32'h0});
        doneQ.push_back(doneExp_t'{id: 0, at: n + 3, r: 32'hDEADBEEF});
        ramQ.push_back(ramExp_t'{id: 0, at: n + 5, addr: 8'd5, wr: 1'b0, wd: 32'h0});
        doneQ.push_back(doneExp_t'{id: 0, at: n + 7, r: 32'h0BADCAFE});
        req[0] = 1'b1;  we[0] = 1'b0;  addr[0] = 32'h10;
        tick();  addr[0] = 32'h30;
        repeat (3) tick();  addr[0] = 32'h14;
        tick();  req[0] = 1'b0;
        repeat (3) tick();

        // Misaligned address 0x22
`ifdef MEM_ALIGN_CHECK_EN
        n = cyc;
        faultQ.push_back(faultExp_t'{id: 0, at: n + 1});
        probeQ.push_back(probe_t'{id: 0, at: n + 2, busy: 1'b0, chkR: 1'b1, r: 32'h0BADCAFE});
        req[0] = 1'b1;  we[0] = 1'b0;  addr[0] = 32'h22;
        tick();  req[0] = 1'b0;
        repeat (3) tick();
`else
        acc(0, 1'b0, 32'h22, 32'h0, 8'd8, 3, 32'h12345678);
`endif

        // dut1 (RD_LAT=3, WR_LAT=2): Busy window for a 3-cycle read
        n = cyc;
        probeQ.push_back(probe_t'{id: 1, at: n,     busy: 1'b0, chkR: 1'b1, r: 32'h0});
        probeQ.push_back(probe_t'{id: 1, at: n + 1, busy: 1'b1, chkR: 1'b0, r: 32'h0});
        probeQ.push_back(probe_t'{id: 1, at: n + 4, busy: 1'b1, chkR: 1'b1, r: 32'h0});
        probeQ.push_back(probe_t'{id: 1, at: n + 5, busy: 1'b0, chkR: 1'b1, r: 32'h11223344});
        acc(1, 1'b0, 32'h0, 32'h0, 8'd0, 5, 32'h11223344);
        acc(1, 1'b1, 32'h8, 32'h55AA55AA, 8'd2, 4, 32'h11223344);
        acc(1, 1'b0, 32'h8, 32'h0, 8'd2, 5, 32'h55AA55AA);

        // Second Req pulsed during WAIT is dropped
        n = cyc;
        ramQ.push_back(ramExp_t'{id: 1, at: n + 1, addr: 8'd1, wr: 1'b0, wd: 32'h0});
        doneQ.push_back(doneExp_t'{id: 1, at: n + 5, r: 32'hCAFEF00D});
        req[1] = 1'b1;  we[1] = 1'b0;  addr[1] = 32'h4;
        tick();  req[1] = 1'b0;
        tick();  req[1] = 1'b1;  we[1] = 1'b1;  addr[1] = 32'h40;  wdata[1] = 32'hFFFFFFFF;
        tick();  req[1] = 1'b0;  we[1] = 1'b0;
        repeat (6) tick();

        // Reset during WAIT abandons the access: no Done, RData cleared
        n = cyc;
        ramQ.push_back(ramExp_t'{id: 1, at: n + 1, addr: 8'd0, wr: 1'b0, wd: 32'h0});
        probeQ.push_back(probe_t'{id: 1, at: n + 2, busy: 1'b1, chkR: 1'b1, r: 32'hCAFEF00D});
        probeQ.push_back(probe_t'{id: 0, at: n + 3, busy: 1'b0, chkR: 1'b1, r: 32'h0});
        probeQ.push_back(probe_t'{id: 1, at: n + 3, busy: 1'b0, chkR: 1'b1, r: 32'h0});
        req[1] = 1'b1;  addr[1] = 32'h0;
        tick();  req[1] = 1'b0;
        tick();  Reset = 1'b1;
        tick();  Reset = 1'b0;
        repeat (8) tick();

        chk("leftover_done", 32'(doneQ.size()), 32'd0);
        chk("leftover_ram", 32'(ramQ.size()), 32'd0);
        chk("leftover_fault", 32'(faultQ.size()), 32'd0);
        chk("leftover_probe", 32'(probeQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
